dma_copy_engine: RTL
====================

# dma_copy_engine

Standalone block-copy DMA engine that sits downstream of the processor control unit. It accepts a copy command (source, destination, length) and moves 32-bit words SRAM-to-SRAM through its own SRAM request port, yielding to processor memory accesses. It exposes the remaining word count for the POLL instruction and a busy flag for HLT draining. Its SRAM port is merged with the processor's port, processor first, by the existing top-level SRAM mux.

## Interface
- ADDR_W, 16, SRAM word-address width; also the width of the length/remaining counter
- DATA_W, 32, SRAM data width
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted); clears all state immediately
- cmd_valid  in  1  copy command present (COPY in EXEC1)
- cmd_ready  out  1  engine can accept a command; equals (state == IDLE)
- cmd_src  in  ADDR_W  first source word address
- cmd_dst  in  ADDR_W  first destination word address
- cmd_len  in  ADDR_W  number of words to copy
- cpu_mem_req  in  1  processor drives the SRAM this cycle; the engine must not
- remaining  out  ADDR_W  words not yet written (POLL value), registered
- busy  out  1  state != IDLE
- sram_ADDR  out  ADDR_W  engine SRAM address
- sram_DI  out  DATA_W  engine SRAM write data
- sram_EN  out  1  engine SRAM enable
- sram_WE  out  1  engine SRAM write enable
- sram_DO  in  DATA_W  SRAM read data; valid the cycle after a read enable

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, NEXT.
- IDLE: if cmd_valid and cmd_len != 0, load src=cmd_src, dst=cmd_dst, remaining=cmd_len, and go to RD_REQ. If cmd_len == 0, the command is accepted and has no effect: stay IDLE, remaining stays 0, no SRAM access.
- RD_REQ: drive EN=1, WE=0, ADDR=src. If cpu_mem_req=1, drive EN=0 and hold the state. Otherwise go to RD_WAIT.
- RD_WAIT: capture sram_DO into the data register unconditionally. No SRAM drive. Go to WR_REQ.
- WR_REQ: drive EN=1, WE=1, ADDR=dst, DI=data. If cpu_mem_req=1, drive EN=0 and hold the state. Otherwise go to NEXT.
- NEXT: remaining -= 1, src += 1, dst += 1. Go to IDLE if remaining was 1, else to RD_REQ.
- SRAM outputs are combinational from the state and cpu_mem_req. Whenever the engine is not driving, ADDR, DI, EN and WE are all 0.
- Addresses wrap modulo 2^ADDR_W (0xFFFF+1 -> 0x0000).
- Copy is ascending, one word at a time, and each word is read before it is written. Overlapping regions with dst > src therefore replicate the source pattern. This is the specified behaviour.
- cmd_valid while busy is ignored (cmd_ready=0). Latched parameters are unaffected.

## Timing
- Reset values: state IDLE, remaining 0, busy 0, cmd_ready 1, sram_EN/WE/ADDR/DI 0, src/dst/data 0.
- Reset asserted mid-copy aborts immediately. SRAM enables drop in the same cycle, with no partial write after reset. Words already written stay written.
- Acceptance edge k (cmd_valid & cmd_ready): busy=1 and RD_REQ from k+1.
- Without contention, each word takes 4 cycles. A len-N copy keeps busy high for exactly 4N cycles, and busy falls at the edge where remaining reaches 0.
- Every cycle of cpu_mem_req=1 during RD_REQ or WR_REQ adds one cycle. cpu_mem_req in RD_WAIT or NEXT has no effect.
- remaining changes only on NEXT edges, so POLL sees N, N-1, …, 0.
- Write of word i is issued in the WR_REQ cycle. Its effect in SRAM is visible to any read issued on a later cycle.

## Test plan
- Basic copy: mem[0x10..0x12]=A,B,C; cmd src=0x10 dst=0x40 len=3, no contention -> mem[0x40..0x42]=A,B,C; busy high 12 cycles; remaining 3,2,1,0 at cycles 4,8,12.
- Contention: same command with cpu_mem_req=1 for 2 cycles in the first RD_REQ and 1 cycle in the third WR_REQ -> engine EN=0 in those cycles; correct data; busy high 15 cycles.
- Zero length and wrap: len=0 -> no SRAM access, busy stays 0. src=0xFFFF dst=0x0100 len=2 -> reads 0xFFFF then 0x0000; writes 0x0100, 0x0101.
- Command while busy: second cmd_valid during a len=4 copy -> ignored; only the first copy occurs; remaining sequence unaffected.
- Reset mid-copy: reset=0 during the WR_REQ of word 2 of 4 -> EN/WE drop in that cycle; word 1 written, word 2 not; after release remaining=0, busy=0, cmd_ready=1.

Source files
------------

// File: rtl/dma_copy_engine.sv
// dma_copy_engine
//   Block-copy DMA engine. Accepts a (src, dst, len) copy command and moves
//   DATA_W-bit words SRAM-to-SRAM one at a time through its own SRAM port.
//   It backs off whenever the processor owns the SRAM in a given cycle.
//
// Ports
//   clk                    single clock, rising edge
//   reset                  asynchronous, active-low
//   cmd_valid/cmd_ready    command handshake; cmd_ready only in IDLE
//   cmd_src/cmd_dst        first source / destination word address
//   cmd_len                number of words to copy (0 = no-op)
//   cpu_mem_req            processor uses the SRAM this cycle; engine yields
//   remaining              words not yet written, registered (POLL value)
//   busy                   engine is not idle
//   sram_ADDR/DI/EN/WE     engine SRAM request; all zero when not driving
//   sram_DO                SRAM read data, valid the cycle after a read enable
module dma_copy_engine #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              cpu_mem_req,
  output logic [ADDR_W-1:0] remaining,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_ADDR,
  output logic [DATA_W-1:0] sram_DI,
  output logic              sram_EN,
  output logic              sram_WE,
  input  logic [DATA_W-1:0] sram_DO
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    NEXT
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q,   src_d;
  logic [ADDR_W-1:0]   dst_q,   dst_d;
  logic [ADDR_W-1:0]   rem_q,   rem_d;
  logic [DATA_W-1:0]   data_q,  data_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end

  // SRAM request is combinational from state and cpu_mem_req, so an
  // asynchronous reset drops the enables in the same cycle.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    data_d    = data_q;
    sram_ADDR = '0;
    sram_DI   = '0;
    sram_EN   = 1'b0;
    sram_WE   = 1'b0;

    case (state_q)
      IDLE: begin
        // A zero-length command is accepted and dropped.
        if (cmd_valid && (cmd_len != '0)) begin
          src_d   = cmd_src;
          dst_d   = cmd_dst;
          rem_d   = cmd_len;
          state_d = RD_REQ;
        end
      end

      RD_REQ: begin
        if (!cpu_mem_req) begin
          sram_EN   = 1'b1;
          sram_ADDR = src_q;
          state_d   = RD_WAIT;
        end
      end

      RD_WAIT: begin
        data_d  = sram_DO;
        state_d = WR_REQ;
      end

      WR_REQ: begin
        if (!cpu_mem_req) begin
          sram_EN   = 1'b1;
          sram_WE   = 1'b1;
          sram_ADDR = dst_q;
          sram_DI   = data_q;
          state_d   = NEXT;
        end
      end

      NEXT: begin
        rem_d   = rem_q - ADDR_W'(1);
        src_d   = src_q + ADDR_W'(1);
        dst_d   = dst_q + ADDR_W'(1);
        state_d = (rem_q == ADDR_W'(1)) ? IDLE : RD_REQ;
      end

      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign remaining = rem_q;

endmodule
